// File: rtl/if_fetch_stage.sv
// if_fetch_stage
// Instruction-fetch stage feeding the IF/ID pipeline register. Owns the fetch
// PC, keeps at most one instruction-memory request in flight (req/gnt/rvalid),
// parks a response in a one-entry skid buffer while IF/ID is stalled, and
// flushes on EX redirects, discarding any response that is still in flight.
//
// Ports
//   clk_IF          clock, rising edge
//   rst_IF          asynchronous reset, active low
//   stall_IF        IF/ID not accepting this cycle
//   redirect_IF     taken branch/jump from EX, flush fetch
//   redirect_PC_IF  redirect target (low two bits ignored)
//   imem_req_IF     fetch request
//   imem_addr_IF    fetch address
//   imem_gnt_IF     request accepted this cycle
//   imem_rvalid_IF  response data valid
//   imem_rdata_IF   response instruction
//   PC_out_IF       PC of the held instruction
//   inst_out_IF     held instruction (NOP_INST while invalid)
//   valid_out_IF    output slot holds a live instruction
//
// state | meaning
// ------+---------------------------------------------------------------
// REQ   | request driven at fetch_pc, waiting for gnt
// WAIT  | request granted, response outstanding
// HOLD  | response parked in skid, output slot full and stalled
// DROP  | response outstanding that must be discarded (redirected)

module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk_IF,
  input  logic        rst_IF,
  input  logic        stall_IF,
  input  logic        redirect_IF,
  input  logic [31:0] redirect_PC_IF,
  output logic        imem_req_IF,
  output logic [31:0] imem_addr_IF,
  input  logic        imem_gnt_IF,
  input  logic        imem_rvalid_IF,
  input  logic [31:0] imem_rdata_IF,
  output logic [31:0] PC_out_IF,
  output logic [31:0] inst_out_IF,
  output logic        valid_out_IF
);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] inst_out_q, inst_out_d;
  logic        valid_out_q, valid_out_d;

  logic [31:0] target;
  logic        load;
  logic [31:0] load_pc;
  logic [31:0] load_inst;

  assign target = {redirect_PC_IF[31:2], 2'b00};

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    load        = 1'b0;
    load_pc     = req_pc_q;
    load_inst   = imem_rdata_IF;

    case (state_q)
      ST_REQ: begin
        if (imem_gnt_IF) begin
          if (redirect_IF) begin
            // Granted request is already stale; its response must be eaten.
            state_d    = ST_DROP;
            fetch_pc_d = target;
          end else begin
            state_d    = ST_WAIT;
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end else if (redirect_IF) begin
          fetch_pc_d = target;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid_IF) begin
          if (redirect_IF) begin
            state_d    = ST_REQ;
            fetch_pc_d = target;
          end else if (!valid_out_q || !stall_IF) begin
            state_d = ST_REQ;
            load    = 1'b1;
          end else begin
            state_d     = ST_HOLD;
            skid_pc_d   = req_pc_q;
            skid_inst_d = imem_rdata_IF;
          end
        end else if (redirect_IF) begin
          state_d    = ST_DROP;
          fetch_pc_d = target;
        end
      end
      ST_HOLD: begin
        if (redirect_IF) begin
          state_d    = ST_REQ;
          fetch_pc_d = target;
        end else if (!stall_IF) begin
          state_d   = ST_REQ;
          load      = 1'b1;
          load_pc   = skid_pc_q;
          load_inst = skid_inst_q;
        end
      end
      ST_DROP: begin
        // Only one response can be pending, so a further redirect just
        // retargets the fetch PC.
        if (redirect_IF) fetch_pc_d = target;
        if (imem_rvalid_IF) state_d = ST_REQ;
      end
      default: state_d = ST_REQ;
    endcase
  end

  // Output slot: redirect flush beats a load, a load beats drain on !stall.
  always_comb begin
    pc_out_d    = pc_out_q;
    inst_out_d  = inst_out_q;
    valid_out_d = valid_out_q;
    if (redirect_IF) begin
      pc_out_d    = 32'd0;
      inst_out_d  = NOP_INST;
      valid_out_d = 1'b0;
    end else if (load) begin
      pc_out_d    = load_pc;
      inst_out_d  = load_inst;
      valid_out_d = 1'b1;
    end else if (!stall_IF) begin
      inst_out_d  = NOP_INST;
      valid_out_d = 1'b0;
    end
  end

  always_ff @(posedge clk_IF or negedge rst_IF) begin
    if (!rst_IF) begin
      state_q     <= ST_REQ;
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= 32'd0;
      skid_pc_q   <= 32'd0;
      skid_inst_q <= 32'd0;
      pc_out_q    <= 32'd0;
      inst_out_q  <= NOP_INST;
      valid_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      pc_out_q    <= pc_out_d;
      inst_out_q  <= inst_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign imem_req_IF  = (state_q == ST_REQ);
  assign imem_addr_IF = fetch_pc_q;
  assign PC_out_IF    = pc_out_q;
  assign inst_out_IF  = inst_out_q;
  assign valid_out_IF = valid_out_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Testbench for if_fetch_stage: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// transaction-level model (pending-request flag, drop flag, skid entry,
// output slot).

module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk_IF = 1'b0;
  logic        rst_IF;
  logic        stall_IF, redirect_IF;
  logic [31:0] redirect_PC_IF;
  logic        imem_req_IF;
  logic [31:0] imem_addr_IF;
  logic        imem_gnt_IF, imem_rvalid_IF;
  logic [31:0] imem_rdata_IF;
  logic [31:0] PC_out_IF, inst_out_IF;
  logic        valid_out_IF;

  // second instance exercising address wrap-around
  logic        w_req, w_rvalid, w_valid;
  logic [31:0] w_addr, w_pc, w_inst;
  logic [31:0] wq[$];

  always #5 clk_IF = ~clk_IF;

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
    .clk_IF(clk_IF), .rst_IF(rst_IF), .stall_IF(stall_IF),
    .redirect_IF(redirect_IF), .redirect_PC_IF(redirect_PC_IF),
    .imem_req_IF(imem_req_IF), .imem_addr_IF(imem_addr_IF),
    .imem_gnt_IF(imem_gnt_IF), .imem_rvalid_IF(imem_rvalid_IF),
    .imem_rdata_IF(imem_rdata_IF), .PC_out_IF(PC_out_IF),
    .inst_out_IF(inst_out_IF), .valid_out_IF(valid_out_IF)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .NOP_INST(NOP)) u_wrap (
    .clk_IF(clk_IF), .rst_IF(rst_IF), .stall_IF(1'b0),
    .redirect_IF(1'b0), .redirect_PC_IF(32'd0),
    .imem_req_IF(w_req), .imem_addr_IF(w_addr),
    .imem_gnt_IF(1'b1), .imem_rvalid_IF(w_rvalid),
    .imem_rdata_IF(32'd0), .PC_out_IF(w_pc),
    .inst_out_IF(w_inst), .valid_out_IF(w_valid)
  );

  always @(posedge clk_IF or negedge rst_IF)
    if (!rst_IF) w_rvalid <= 1'b0;
    else         w_rvalid <= w_req;

  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;

  // model state
  logic [31:0] m_pc;
  bit          m_out, m_drop;
  logic [31:0] m_req_pc;
  bit          m_skid_v;
  logic [31:0] m_skid_pc, m_skid_inst;
  bit          m_slot_v;
  logic [31:0] m_slot_pc, m_slot_inst;

  // memory responder state
  bit          pend;
  int          cnt;
  logic [31:0] pend_addr;
  int          fixed_lat = 1;
  logic        req_seen;
  logic [31:0] addr_seen;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_out = 0; m_drop = 0; m_req_pc = 32'h0;
    m_skid_v = 0; m_skid_pc = 32'h0; m_skid_inst = 32'h0;
    m_slot_v = 0; m_slot_pc = 32'h0; m_slot_inst = NOP;
    pend = 0; cnt = 0; pend_addr = 32'h0;
  endtask

  // One clock edge of the fetch stage, in terms of transactions.
  task automatic model_update();
    logic [31:0] tgt, ld_pc, ld_inst;
    bit          ld, can_req;
    tgt     = {redirect_PC_IF[31:2], 2'b00};
    ld      = 0;
    ld_pc   = 32'h0;
    ld_inst = 32'h0;
    can_req = !m_out && !m_skid_v;
    if (can_req) begin
      if (imem_gnt_IF) begin
        m_out  = 1;
        m_drop = redirect_IF;
        if (redirect_IF) m_pc = tgt;
        else begin m_req_pc = m_pc; m_pc = m_pc + 32'd4; end
      end else if (redirect_IF) m_pc = tgt;
    end else if (m_out) begin
      if (imem_rvalid_IF) begin
        m_out = 0;
        if (!m_drop && !redirect_IF) begin
          if (!m_slot_v || !stall_IF) begin
            ld = 1; ld_pc = m_req_pc; ld_inst = imem_rdata_IF;
          end else begin
            m_skid_v = 1; m_skid_pc = m_req_pc; m_skid_inst = imem_rdata_IF;
          end
        end
        m_drop = 0;
      end else if (redirect_IF) m_drop = 1;
      if (redirect_IF) m_pc = tgt;
    end else begin
      if (redirect_IF) begin
        m_skid_v = 0; m_pc = tgt;
      end else if (!stall_IF) begin
        m_skid_v = 0; ld = 1; ld_pc = m_skid_pc; ld_inst = m_skid_inst;
      end
    end
    if (redirect_IF) begin
      m_slot_v = 0; m_slot_pc = 32'h0; m_slot_inst = NOP;
    end else if (ld) begin
      m_slot_v = 1; m_slot_pc = ld_pc; m_slot_inst = ld_inst;
    end else if (!stall_IF) begin
      m_slot_v = 0; m_slot_inst = NOP;
    end
  endtask

  task automatic responder_update();
    if (imem_rvalid_IF) pend = 0;
    else if (pend && cnt > 0) cnt--;
    if (req_seen && imem_gnt_IF) begin
      pend      = 1;
      pend_addr = addr_seen;
      cnt       = (fixed_lat > 0) ? fixed_lat - 1 : int'($urandom_range(2, 0));
    end
  endtask

  task automatic step(input logic g, input logic st, input logic rd, input logic [31:0] rp);
    @(negedge clk_IF);
    req_seen       = imem_req_IF;
    addr_seen      = imem_addr_IF;
    imem_gnt_IF    = g;
    stall_IF       = st;
    redirect_IF    = rd;
    redirect_PC_IF = rp;
    imem_rvalid_IF = pend && (cnt == 0);
    imem_rdata_IF  = pend ? (pend_addr ^ KEY) : $urandom;
    @(posedge clk_IF);
    n_vec++;
    if (rst_IF) begin
      model_update();
      responder_update();
    end
  endtask

  // compare process: DUT against model on every cycle
  always @(negedge clk_IF) begin
    if (chk_en) begin
      chk("req", {31'd0, imem_req_IF}, {31'd0, !m_out && !m_skid_v});
      if (!m_out && !m_skid_v) chk("addr", imem_addr_IF, m_pc);
      chk("valid", {31'd0, valid_out_IF}, {31'd0, m_slot_v});
      if (m_slot_v) begin
        chk("pc_out", PC_out_IF, m_slot_pc);
        chk("inst_out", inst_out_IF, m_slot_inst);
      end else begin
        chk("inst_nop", inst_out_IF, NOP);
      end
      if (w_req && wq.size() < 3) wq.push_back(w_addr);
    end
  end

  initial begin
    rst_IF = 1'b0; stall_IF = 0; redirect_IF = 0; redirect_PC_IF = 32'h0;
    imem_gnt_IF = 0; imem_rvalid_IF = 0; imem_rdata_IF = 32'h0;
    req_seen = 0; addr_seen = 32'h0;
    model_reset();
    repeat (2) @(posedge clk_IF);
    #1;
    chk("rst_valid", {31'd0, valid_out_IF}, 32'd0);
    chk("rst_pc", PC_out_IF, 32'h0);
    chk("rst_inst", inst_out_IF, NOP);
    #1 rst_IF = 1'b1; chk_en = 1;
    #1 chk("t1_addr0", imem_addr_IF, 32'h0);

    // free-running, latency 1, no stall
    fixed_lat = 1;
    step(1, 0, 0, 0); #1 chk("t1_wait_noreq", {31'd0, imem_req_IF}, 32'd0);
    step(1, 0, 0, 0); #1 chk("t1_pc0", PC_out_IF, 32'h0);
    chk("t1_inst0", inst_out_IF, 32'hA5A5_0000);
    chk("t1_addr4", imem_addr_IF, 32'h4);
    step(1, 0, 0, 0); #1 chk("t1_gap", {31'd0, valid_out_IF}, 32'd0);
    step(1, 0, 0, 0); #1 chk("t1_pc4", PC_out_IF, 32'h4);
    chk("t1_addr8", imem_addr_IF, 32'h8);

    // stall 5 cycles with PC 4 held and PC 8 arriving
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
    #1 chk("t2_hold_pc4", PC_out_IF, 32'h4);
    chk("t2_hold_valid", {31'd0, valid_out_IF}, 32'd1);
    step(1, 0, 0, 0); #1 chk("t2_pc8", PC_out_IF, 32'h8);
    chk("t2_inst8", inst_out_IF, 32'hA5A5_0008);

    // redirect during WAIT, response 2 cycles after grant is dropped
    fixed_lat = 2;
    step(1, 0, 0, 0);
    step(1, 0, 1, 32'h0000_0103); #1 chk("t3_valid0", {31'd0, valid_out_IF}, 32'd0);
    fixed_lat = 1;
    step(1, 0, 0, 0); #1 chk("t3_addr100", imem_addr_IF, 32'h100);
    chk("t3_still_invalid", {31'd0, valid_out_IF}, 32'd0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0); #1 chk("t3_pc100", PC_out_IF, 32'h100);

    // redirect coinciding with rvalid while stalled with a valid output
    step(1, 1, 0, 0);
    step(0, 1, 1, 32'h0000_0200); #1 chk("t4_valid", {31'd0, valid_out_IF}, 32'd0);
    chk("t4_nop", inst_out_IF, NOP);
    chk("t4_pc0", PC_out_IF, 32'h0);
    chk("t4_addr", imem_addr_IF, 32'h200);

    // reset while in WAIT with a valid output
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    fixed_lat = 3;
    step(1, 1, 0, 0); #1 chk("t6_pre_valid", {31'd0, valid_out_IF}, 32'd1);
    #2 rst_IF = 1'b0; chk_en = 0;
    #1 chk("t6_valid", {31'd0, valid_out_IF}, 32'd0);
    chk("t6_pc", PC_out_IF, 32'h0);
    chk("t6_inst", inst_out_IF, NOP);
    model_reset();
    stall_IF = 0; imem_gnt_IF = 0; imem_rvalid_IF = 0;
    repeat (2) @(posedge clk_IF);
    #2 rst_IF = 1'b1; chk_en = 1;
    #1 chk("t6_addr_reset_pc", imem_addr_IF, 32'h0);

    // randomized traffic
    fixed_lat = 0;
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] rp;
      rp = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step(($urandom_range(99, 0) < 60) ? 1'b1 : 1'b0,
           ($urandom_range(99, 0) < 35) ? 1'b1 : 1'b0,
           ($urandom_range(99, 0) < 7)  ? 1'b1 : 1'b0, rp);
    end
    @(negedge clk_IF);
    chk_en = 0;

    if (wq.size() < 3) begin
      n_cmp++; n_err++;
      $display("FAIL wrap_count: got %0d addresses expected 3", wq.size());
    end else begin
      chk("wrap_a0", wq[0], 32'hFFFF_FFF8);
      chk("wrap_a1", wq[1], 32'hFFFF_FFFC);
      chk("wrap_a2", wq[2], 32'h0000_0000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the fetch PC, issues one request at a time to instruction memory over a req/gnt/rvalid handshake, and holds the fetched {PC, instruction, valid} for the IF/ID register. It absorbs downstream stalls in a one-entry skid buffer and honours branch/jump redirects from EX by flushing and discarding stale responses.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INST, 32'h0000_0013, instruction value driven while output invalid/after reset

Ports:
clk_IF  in  1  clock, rising edge
rst_IF  in  1  reset, asynchronous, active-low
stall_IF  in  1  1 = IF/ID not accepting this cycle (IF/ID en low)
redirect_IF  in  1  1 = taken branch/jump, flush fetch
redirect_PC_IF  in  32  redirect target
imem_req_IF  out  1  fetch request
imem_addr_IF  out  32  fetch address
imem_gnt_IF  in  1  request accepted this cycle
imem_rvalid_IF  in  1  response data valid
imem_rdata_IF  in  32  response instruction
PC_out_IF  out  32  PC of held instruction, to IF/ID
inst_out_IF  out  32  held instruction, to IF/ID
valid_out_IF  out  1  output slot holds a live instruction

Behaviour:
- Reset (rst_IF=0, async): state=REQ, fetch_pc=RESET_PC, req_pc=0, skid empty; PC_out_IF=0, inst_out_IF=NOP_INST, valid_out_IF=0. Outputs settle without a clock edge.
- imem_req_IF = (state==REQ); imem_addr_IF = fetch_pc (combinational from registers). At most one outstanding request.
- Redirect target low 2 bits forced to 0. fetch_pc+4 wraps mod 2^32 (FFFF_FFFC -> 0000_0000).
- States: REQ, WAIT (request outstanding), HOLD (response parked in skid, output full and stalled), DROP (outstanding response to discard).
- REQ: gnt & !redirect -> WAIT, req_pc<=fetch_pc, fetch_pc<=fetch_pc+4. gnt & redirect -> DROP, fetch_pc<=redirect target. !gnt & redirect -> stay REQ, fetch_pc<=target (address may change while ungranted).
- WAIT: rvalid & redirect -> REQ, response discarded, fetch_pc<=target. rvalid & slot free (valid_out_IF==0 or stall_IF==0) -> REQ, output<={req_pc, rdata, 1}. rvalid & slot full & stall_IF -> HOLD, skid<={req_pc, rdata}. !rvalid & redirect -> DROP, fetch_pc<=target.
- HOLD: redirect -> REQ, skid discarded, fetch_pc<=target. !stall_IF -> REQ, output<=skid, valid 1. Else stay.
- DROP: rvalid -> REQ, data discarded. Redirect in DROP: fetch_pc<=new target, stay DROP (only one response pending).
- Output slot: redirect clears valid_out_IF at the edge (PC_out_IF/inst_out_IF become 0/NOP_INST), priority over stall and over any load that cycle. Else if loaded -> new contents. Else if stall_IF==0 -> valid_out_IF<=0, inst_out_IF<=NOP_INST. Else hold all three.
- Latency: gnt at cycle n, rvalid at n+k (k>=1) -> valid_out_IF from cycle n+k+1. Peak throughput 1 instruction per 2 cycles (gnt and rvalid each 1 cycle).
- Reset mid-operation: any outstanding response arriving after reset release while in REQ is ignored (rvalid only honoured in WAIT/DROP); memory must not return data for pre-reset requests after the first post-reset gnt.
- rvalid in REQ or HOLD is a protocol error; ignored.

Test Plan:
- Reset release, gnt/rvalid every cycle, no stall, rdata=addr^32'hA5A5_0000 -> imem_addr 0,4,8 on successive REQ cycles; valid_out with PC 0,4,8 every 2nd cycle, first at 2 cycles after first gnt.
- stall_IF=1 held 5 cycles while PC 4 in output and PC 8 response arrives -> HOLD, output stays PC 4; on release output PC 8 next edge, no instruction lost or duplicated.
- redirect_IF to 32'h0000_0103 during WAIT, rvalid 2 cycles later -> DROP, response discarded, next imem_addr=0000_0100, valid_out_IF=0 until PC 100 returns.
- redirect in same cycle as rvalid with stall_IF=1 and valid output -> valid_out_IF=0, inst_out_IF=NOP_INST, next request at target.
- RESET_PC=32'hFFFF_FFF8, free-running -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert rst_IF=0 in WAIT with valid output -> outputs 0/NOP_INST/0 immediately; after release first imem_addr=RESET_PC.
